input_loader: RTL and testbench

Byte-stream frame parser that fills the two input sample memories of the Input stage before a CPU run. It sits between the host UART receiver and the Input block's write port (in1_write/in2_write/addr_in/data_in). It decodes framed 12-bit words, writes them at sequential addresses, checks a checksum, and holds the CPU in reset while loading.

---
 rtl/hovalaag_pkg.sv | 24 ++
 rtl/loader_timeout.sv | 30 +++
 rtl/input_loader.sv | 151 +++++++++++++++
 tb/tb_input_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hovalaag_pkg.sv
// Shared constants and types for the Input-stage loader.
package hovalaag_pkg;

    // Frame command bytes selecting the target sample memory
    localparam logic [7:0] CMD_IN1 = 8'h01;
    localparam logic [7:0] CMD_IN2 = 8'h02;

    // Error codes reported on err_code
    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CMD     = 3'd1;
    localparam logic [2:0] ERR_NIBBLE  = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_CSUM    = 3'd4;

    // Parser states; one state per expected byte kind
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_HI,
        ST_LO,
        ST_CSUM
    } loader_state_t;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle counter; flags expiry after TIMEOUT_CYCLES-1 quiet cycles.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_cnt;

    // Count idle cycles, saturating at LIMIT so expiry stays asserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/input_loader.sv
// Framed byte-stream parser that writes 12-bit samples into the Input
// stage memories and holds the CPU in reset while a frame is in flight.
module input_loader
    import hovalaag_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        in1_write,
    output logic        in2_write,
    output logic [7:0]  addr_in,
    output logic [11:0] data_in,
    output logic        busy,
    output logic        load_done,
    output logic        load_err,
    output logic [2:0]  err_code,
    output logic [8:0]  word_count
);

    loader_state_t r_state;
    logic          r_sel2;      // 1: frame targets input 2 memory
    logic [8:0]    r_remain;    // words still to receive (LEN 0 -> 256)
    logic [7:0]    r_idx;       // next write address, wraps naturally
    logic [7:0]    r_csum;      // running sum of LEN/HI/LO bytes
    logic [3:0]    r_hi;        // upper data nibble latched from HI byte

    logic r_in1_write, r_in2_write, r_busy, r_load_done, r_load_err;
    logic [7:0]  r_addr;
    logic [11:0] r_data;
    logic [2:0]  r_err_code;
    logic [8:0]  r_word_count;

    logic w_expired;
    logic w_to_clear;

    // Idle counter only runs inside a frame; every received byte restarts it
    assign w_to_clear = rx_valid || (r_state == ST_IDLE);

    loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_to_clear),
        .i_enable  (1'b1),
        .o_expired (w_expired)
    );

    // Parser FSM with registered write port, status pulses and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sel2       <= 1'b0;
            r_remain     <= '0;
            r_idx        <= '0;
            r_csum       <= '0;
            r_hi         <= '0;
            r_in1_write  <= 1'b0;
            r_in2_write  <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_busy       <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_word_count <= '0;
        end else begin
            r_in1_write <= 1'b0;
            r_in2_write <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            // busy covers the terminating pulse cycle, then drops
            if (r_load_done || r_load_err)
                r_busy <= 1'b0;

            if ((r_state != ST_IDLE) && !rx_valid && w_expired) begin
                r_load_err <= 1'b1;
                r_err_code <= ERR_TIMEOUT;
                r_state    <= ST_IDLE;
            end else if (rx_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if ((rx_data == CMD_IN1) || (rx_data == CMD_IN2)) begin
                            r_sel2       <= (rx_data == CMD_IN2);
                            r_busy       <= 1'b1;
                            r_word_count <= '0;
                            r_state      <= ST_LEN;
                        end else begin
                            r_load_err <= 1'b1;
                            r_err_code <= ERR_CMD;
                        end
                    end
                    ST_LEN: begin
                        r_remain <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        r_csum   <= rx_data;
                        r_idx    <= '0;
                        r_state  <= ST_HI;
                    end
                    ST_HI: begin
                        if (rx_data[7:4] != 4'd0) begin
                            r_load_err <= 1'b1;
                            r_err_code <= ERR_NIBBLE;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_hi    <= rx_data[3:0];
                            r_csum  <= r_csum + rx_data;
                            r_state <= ST_LO;
                        end
                    end
                    ST_LO: begin
                        r_in1_write  <= !r_sel2;
                        r_in2_write  <= r_sel2;
                        r_addr       <= r_idx;
                        r_data       <= {r_hi, rx_data};
                        r_idx        <= r_idx + 8'd1;
                        r_csum       <= r_csum + rx_data;
                        r_word_count <= r_word_count + 9'd1;
                        r_remain     <= r_remain - 9'd1;
                        r_state      <= (r_remain == 9'd1) ? ST_CSUM : ST_HI;
                    end
                    ST_CSUM: begin
                        if (rx_data == r_csum) begin
                            r_load_done <= 1'b1;
                        end else begin
                            r_load_err <= 1'b1;
                            r_err_code <= ERR_CSUM;
                        end
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign in1_write  = r_in1_write;
    assign in2_write  = r_in2_write;
    assign addr_in    = r_addr;
    assign data_in    = r_data;
    assign busy       = r_busy;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign err_code   = r_err_code;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_input_loader.sv
// Directed bench for input_loader: per-cycle vector table plus hand sequences.
module tb_input_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        in1_write, in2_write, busy, load_done, load_err;
    logic [7:0]  addr_in;
    logic [11:0] data_in;
    logic [2:0]  err_code;
    logic [8:0]  word_count;

    input_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .in1_write  (in1_write),
        .in2_write  (in2_write),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .busy       (busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .err_code   (err_code),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Write/pulse monitor, sampled on the falling edge
    int          wr_n = 0;
    int          n_done = 0;
    int          n_err = 0;
    bit          coincide = 1'b0;
    bit          both_wr = 1'b0;
    logic [1:0]  wr_port [0:1023];
    logic [7:0]  wr_addr [0:1023];
    logic [11:0] wr_data [0:1023];

    always @(negedge clk) begin
        if (!rst) begin
            if (in1_write || in2_write) begin
                if (wr_n < 1024) begin
                    wr_port[wr_n] = in2_write ? 2'd2 : 2'd1;
                    wr_addr[wr_n] = addr_in;
                    wr_data[wr_n] = data_in;
                end
                wr_n = wr_n + 1;
            end
            if (in1_write && in2_write) both_wr = 1'b1;
            if (load_done) n_done = n_done + 1;
            if (load_err)  n_err  = n_err + 1;
            if (load_done && load_err) coincide = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_t1(input logic [7:0] cs);
        send(8'h01); send(8'h02); send(8'h01); send(8'h23);
        send(8'h0A); send(8'hBC); send(cs);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic        v;
        logic        w1;
        logic        w2;
        logic [7:0]  a;
        logic [11:0] dat;
        logic        bsy;
        logic        done;
        logic        err;
        logic [2:0]  ec;
        logic [8:0]  wc;
    } vec_t;

    vec_t tbl [0:7];

    initial begin
        int          base;
        int          nd;
        int          ne;
        logic [7:0]  cs;

        // Frame 01 02 01 23 0A BC EC; expected outputs after each edge
        tbl[0] = '{8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0};
        tbl[1] = '{8'h02, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0};
        tbl[2] = '{8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0};
        tbl[3] = '{8'h23, 1'b1, 1'b1, 1'b0, 8'h00, 12'h123, 1'b1, 1'b0, 1'b0, 3'd0, 9'd1};
        tbl[4] = '{8'h0A, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0, 3'd0, 9'd1};
        tbl[5] = '{8'hBC, 1'b1, 1'b1, 1'b0, 8'h01, 12'hABC, 1'b1, 1'b0, 1'b0, 3'd0, 9'd2};
        tbl[6] = '{8'hEC, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000, 1'b1, 1'b1, 1'b0, 3'd0, 9'd2};
        tbl[7] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 3'd0, 9'd2};

        // Reset state
        idle(3);
        rst = 1'b0;
        #1;
        chk("rst_in1_write", 32'(in1_write), 32'd0);
        chk("rst_in2_write", 32'(in2_write), 32'd0);
        chk("rst_addr", 32'(addr_in), 32'd0);
        chk("rst_data", 32'(data_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        idle(1);

        // Table-driven basic frame
        for (int i = 0; i < 8; i++) begin
            rx_data  = tbl[i].d;
            rx_valid = tbl[i].v;
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            chk($sformatf("t1_in1_write[%0d]", i), 32'(in1_write), 32'(tbl[i].w1));
            chk($sformatf("t1_in2_write[%0d]", i), 32'(in2_write), 32'(tbl[i].w2));
            if (tbl[i].w1 || tbl[i].w2) begin
                chk($sformatf("t1_addr[%0d]", i), 32'(addr_in), 32'(tbl[i].a));
                chk($sformatf("t1_data[%0d]", i), 32'(data_in), 32'(tbl[i].dat));
            end
            chk($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("t1_done[%0d]", i), 32'(load_done), 32'(tbl[i].done));
            chk($sformatf("t1_err[%0d]", i), 32'(load_err), 32'(tbl[i].err));
            chk($sformatf("t1_err_code[%0d]", i), 32'(err_code), 32'(tbl[i].ec));
            chk($sformatf("t1_word_count[%0d]", i), 32'(word_count), 32'(tbl[i].wc));
        end

        // 256-word frame to input 2, data = index
        base = wr_n; ne = n_err;
        send(8'h02); send(8'h00);
        cs = 8'h00;
        for (int i = 0; i < 256; i++) begin
            send(8'h00);
            send(8'(i));
            cs = cs + 8'(i);
        end
        send(cs);
        chk("t2_done", 32'(load_done), 32'd1);
        chk("t2_word_count", 32'(word_count), 32'd256);
        idle(2);
        chk("t2_busy_after", 32'(busy), 32'd0);
        chk("t2_nwrites", 32'(wr_n - base), 32'd256);
        chk("t2_no_err", 32'(n_err - ne), 32'd0);
        for (int i = 0; i < 256; i++) begin
            if (base + i < 1024) begin
                chk($sformatf("t2_port[%0d]", i), 32'(wr_port[base+i]), 32'd2);
                chk($sformatf("t2_addr[%0d]", i), 32'(wr_addr[base+i]), 32'(i));
                chk($sformatf("t2_data[%0d]", i), 32'(wr_data[base+i]), 32'(i));
            end
        end

        // Bad checksum: writes land, error reported
        base = wr_n; nd = n_done;
        send_t1(8'hED);
        chk("t3_err", 32'(load_err), 32'd1);
        chk("t3_err_code", 32'(err_code), 32'd4);
        chk("t3_done", 32'(load_done), 32'd0);
        idle(2);
        chk("t3_nwrites", 32'(wr_n - base), 32'd2);
        chk("t3_no_done", 32'(n_done - nd), 32'd0);
        chk("t3_busy_after", 32'(busy), 32'd0);

        // Timeout mid-frame, then a clean frame
        base = wr_n;
        send(8'h01); send(8'h01); send(8'h01);
        for (int i = 0; i < 40 && !load_err; i++) begin
            @(posedge clk);
            #1;
        end
        chk("t4_timeout_err", 32'(load_err), 32'd1);
        chk("t4_err_code", 32'(err_code), 32'd3);
        idle(1);
        chk("t4_busy_after", 32'(busy), 32'd0);
        chk("t4_no_write", 32'(wr_n - base), 32'd0);
        base = wr_n;
        send_t1(8'hEC);
        chk("t4_reload_done", 32'(load_done), 32'd1);
        chk("t4_err_code_held", 32'(err_code), 32'd3);
        idle(1);
        chk("t4_reload_nwrites", 32'(wr_n - base), 32'd2);

        // Invalid command and bad HI nibble
        base = wr_n;
        send(8'h05);
        chk("t5_cmd_err", 32'(load_err), 32'd1);
        chk("t5_cmd_code", 32'(err_code), 32'd1);
        chk("t5_cmd_busy", 32'(busy), 32'd0);
        send(8'h01); send(8'h01); send(8'hF1);
        chk("t5_nib_err", 32'(load_err), 32'd1);
        chk("t5_nib_code", 32'(err_code), 32'd2);
        idle(2);
        chk("t5_nib_busy", 32'(busy), 32'd0);
        chk("t5_no_write", 32'(wr_n - base), 32'd0);

        // Reset mid-frame, then a full frame from address 0
        nd = n_done; ne = n_err;
        send(8'h01); send(8'h02); send(8'h01);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_err_code", 32'(err_code), 32'd0);
        chk("t6_rst_word_count", 32'(word_count), 32'd0);
        chk("t6_rst_addr", 32'(addr_in), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        chk("t6_no_pulse", 32'((n_done - nd) + (n_err - ne)), 32'd0);
        base = wr_n;
        send_t1(8'hEC);
        chk("t6_done", 32'(load_done), 32'd1);
        idle(1);
        chk("t6_nwrites", 32'(wr_n - base), 32'd2);
        if (wr_n - base >= 2 && base + 1 < 1024) begin
            chk("t6_addr0", 32'(wr_addr[base]), 32'd0);
            chk("t6_data0", 32'(wr_data[base]), 32'h123);
            chk("t6_port0", 32'(wr_port[base]), 32'd1);
            chk("t6_addr1", 32'(wr_addr[base+1]), 32'd1);
            chk("t6_data1", 32'(wr_data[base+1]), 32'hABC);
        end

        chk("pulse_coincide", 32'(coincide), 32'd0);
        chk("dual_write", 32'(both_wr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
